seq_mult: RTL and testbench

Parametrised sequential shift-add multiplier: multiplies two W-bit operands over W clock cycles and returns a 2W-bit product under a start/done handshake. It replaces the fixed 3x3 combinational array multiplier wherever operand width grows beyond a few bits and area matters more than latency. It sits between an operand-issuing controller and a result consumer, one multiply in flight at a time.

---
 rtl/seq_mult_pkg.sv | 27 ++
 rtl/seq_mult_if.sv | 24 ++
 rtl/seq_mult_step.sv | 25 ++
 rtl/seq_mult.sv | 114 +++++++++++
 tb/tb_seq_mult.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// ============================================================================
//  mult_pkg
//  Shared types and helpers for the sequential shift-add multiplier.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int MULT_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult_if.sv
// ============================================================================
//  seq_mult_if
//  Start/done handshake and operand/product bus of the sequential multiplier.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_mult_if
    import mult_pkg::*;
#(
    parameter int W = MULT_W_DEFAULT
);
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] S;

    modport master (output start, A, B, input busy, done, S);
    modport slave  (input start, A, B, output busy, done, S);
endinterface

`default_nettype wire

// File: rtl/seq_mult_step.sv
// ============================================================================
//  mult_step
//  One shift-add iteration: conditional add of the multiplicand to the
//  accumulator upper half, carry kept in the (W+1)-bit sum.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_step
    import mult_pkg::*;
#(
    parameter int W = MULT_W_DEFAULT
) (
    input  wire logic [W-1:0] multiplicand,
    input  wire logic [W-1:0] acc_hi,
    input  wire logic         mplier_lsb,
    output logic      [W:0]   sum
);
    logic [W:0] w_addend;

    assign w_addend = mplier_lsb ? {1'b0, multiplicand} : '0;
    assign sum      = {1'b0, acc_hi} + w_addend;
endmodule

`default_nettype wire

// File: rtl/seq_mult.sv
// ============================================================================
//  seq_mult
//  W-bit sequential shift-add multiplier, one product every W+1 cycles.
//  Optional macro SEQ_MULT_SIGNED_EN: two's complement operands and product.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult
    import mult_pkg::*;
#(
    parameter int W = MULT_W_DEFAULT
) (
    input wire logic  clk,
    input wire logic  rst,
    seq_mult_if.slave bus
);
    localparam int                 c_cnt_w    = clog2(W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(W - 1);

    state_t               r_state;
    logic [W-1:0]         r_mcand;
    logic [W-1:0]         r_mplier;
    logic [2*W-1:0]       r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2*W-1:0]       r_s;
    logic                 r_busy;
    logic                 r_done;

    logic [W:0]           w_sum;
    logic [2*W-1:0]       w_next_acc;
    logic [W-1:0]         w_a_load;
    logic [W-1:0]         w_b_load;
    logic [2*W-1:0]       w_result;

    mult_step #(.W(W)) u_step (
        .multiplicand (r_mcand),
        .acc_hi       (r_acc[2*W-1:W]),
        .mplier_lsb   (r_mplier[0]),
        .sum          (w_sum)
    );

    // {carry, accumulator} shifted right by one: the lowest bit falls off
    assign w_next_acc = {w_sum, r_acc[W-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
    logic r_sign;

    // Magnitude of the most-negative value is still correct as an unsigned W-bit number
    assign w_a_load = bus.A[W-1] ? -bus.A : bus.A;
    assign w_b_load = bus.B[W-1] ? -bus.B : bus.B;
    assign w_result = r_sign ? -w_next_acc : w_next_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if ((r_state != RUN) && bus.start) begin
            r_sign <= bus.A[W-1] ^ bus.B[W-1];
        end
    end
`else
    assign w_a_load = bus.A;
    assign w_b_load = bus.B;
    assign w_result = w_next_acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_s      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_mcand  <= w_a_load;
                        r_mplier <= w_b_load;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_acc    <= w_next_acc;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        r_s     <= w_result;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.S    = r_s;
endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
// ============================================================================
//  tb_seq_mult
//  Directed scoreboard bench for seq_mult at W=3.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mult;
    localparam int W = 3;

`ifdef SEQ_MULT_SIGNED_EN
    localparam logic [5:0] E77 = 6'd1;
    localparam logic [5:0] E76 = 6'd2;
    localparam logic [5:0] E56 = 6'd6;
    localparam logic [5:0] E43 = 6'b110100;
`else
    localparam logic [5:0] E77 = 6'd49;
    localparam logic [5:0] E76 = 6'd42;
    localparam logic [5:0] E56 = 6'd30;
    localparam logic [5:0] E43 = 6'b001100;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [5:0] exp_q[$];
    logic prev_done;

    seq_mult_if #(.W(W)) m_if ();

    seq_mult #(.W(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending result
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (m_if.done) begin
                chk("done_not_consecutive", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("product", {26'd0, m_if.S}, {26'd0, exp_q.pop_front()});
                end
            end
            prev_done = m_if.done;
        end
    end

    // Single multiply from idle, with latency and busy-window checks
    task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [5:0] e);
        @(posedge clk); #1;
        m_if.start = 1'b1; m_if.A = a; m_if.B = b;
        @(posedge clk);
        exp_q.push_back(e);
        #1 m_if.start = 1'b0; m_if.A = '0; m_if.B = '0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("busy_in_run", {31'd0, m_if.busy}, 32'd1);
            chk("no_done_in_run", {31'd0, m_if.done}, 32'd0);
        end
        @(negedge clk);
        chk("done_latency", {31'd0, m_if.done}, 32'd1);
        chk("busy_low_at_done", {31'd0, m_if.busy}, 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0; prev_done = 1'b0;
        rst = 1'b1;
        m_if.start = 1'b0; m_if.A = '0; m_if.B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, m_if.busy}, 32'd0);
        chk("reset_done", {31'd0, m_if.done}, 32'd0);
        chk("reset_S", {26'd0, m_if.S}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        issue(3'd7, 3'd7, E77);
        repeat (5) @(negedge clk);
        chk("S_holds", {26'd0, m_if.S}, {26'd0, E77});

        issue(3'd0, 3'd5, 6'd0);
        issue(3'd5, 3'd0, 6'd0);

        // Start during RUN must be ignored
        @(posedge clk); #1;
        m_if.start = 1'b1; m_if.A = 3'd3; m_if.B = 3'd2;
        @(posedge clk);
        exp_q.push_back(6'd6);
        #1 m_if.start = 1'b0;
        @(posedge clk); #1;
        m_if.start = 1'b1; m_if.A = 3'd7; m_if.B = 3'd7;
        @(posedge clk); #1 m_if.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("ignored_start_S", {26'd0, m_if.S}, 32'd6);
        chk("ignored_start_idle", {31'd0, m_if.busy}, 32'd0);

        // Asynchronous reset in the second RUN cycle
        @(posedge clk); #1;
        m_if.start = 1'b1; m_if.A = 3'd5; m_if.B = 3'd6;
        @(posedge clk); #1 m_if.start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, m_if.busy}, 32'd0);
        chk("async_rst_done", {31'd0, m_if.done}, 32'd0);
        chk("async_rst_S", {26'd0, m_if.S}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_done_after_rst", {26'd0, m_if.S}, 32'd0);
        issue(3'd5, 3'd6, E56);

        // Back-to-back with start held high
        @(posedge clk); #1;
        m_if.start = 1'b1; m_if.A = 3'd2; m_if.B = 3'd3;
        @(posedge clk);
        exp_q.push_back(6'd6);
        #1 m_if.A = 3'd7; m_if.B = 3'd6;
        repeat (W) @(negedge clk);
        @(negedge clk);
        chk("b2b_first_done", {31'd0, m_if.done}, 32'd1);
        @(posedge clk);
        exp_q.push_back(E76);
        #1 m_if.start = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("b2b_gap_no_done", {31'd0, m_if.done}, 32'd0);
        end
        @(negedge clk);
        chk("b2b_second_done", {31'd0, m_if.done}, 32'd1);

        issue(3'b100, 3'b011, E43);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
